program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader that sits directly upstream of the VLIW core and `main_memory`. After reset it accepts a byte stream (header, instruction/data words, checksum) over a valid/ready handshake. It assembles the stream into 32-bit little-endian words and writes them into `main_memory` through a dedicated write port. It asserts `core_run` only after a verified load, and the top level uses `core_run` to hold the core's program counter and pipeline idle.

## Interface
Parameters:
- `ADDR_W`, 32, memory byte-address width
- `BASE_ADDR`, 0, byte address of the first loaded word
- `MAX_WORDS`, 1024, largest accepted word count

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  byte available on `in_data`
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader can accept a byte this cycle
- `restart`  in  1  re-arm from DONE/ERROR
- `mem_wr_en`  out  1  one-cycle memory write strobe
- `mem_wr_addr`  out  ADDR_W  word-aligned byte address
- `mem_wr_data`  out  32  word to write
- `busy`  out  1  load in progress (HDR..CSUM)
- `done`  out  1  load verified
- `error`  out  1  load rejected; sticky until `restart` or reset
- `core_run`  out  1  core may fetch/execute

## Operation
- Stream format, all fields 4 bytes, least-significant byte first:
  - word count N
  - N payload words
  - checksum, equal to the XOR of all N payload words
- A byte transfers when `in_valid && in_ready`.
- States and transitions:
  - HDR: accept 4 count bytes, then go to CHECK.
  - CHECK: one cycle, `in_ready`=0. If N==0 or N>MAX_WORDS, go to ERROR; else go to DATA.
  - DATA: accept 4 bytes. On the 4th byte, latch the word and go to WRITE.
  - WRITE: one cycle with `in_ready`=0 and `mem_wr_en`=1.
    - `mem_wr_addr` = BASE_ADDR + 4·idx; `mem_wr_data` = assembled word.
    - The word is XORed into the running checksum, and idx increments.
    - Next state is DATA if idx+1<N, else CSUM.
  - CSUM: accept 4 bytes. On the 4th byte, compare {in_data, shift[23:0]} with the running checksum. Go to DONE on match, ERROR on mismatch.
  - DONE: `done`=`core_run`=1.
  - ERROR: `error`=1, `core_run`=0.
  - In DONE or ERROR, `restart`=1 returns to HDR and clears idx, the byte counter and the checksum. `restart` is ignored in all other states.
- `in_ready` = 1 in HDR, DATA and CSUM only.
- Payload writes already performed before an error are not undone. `core_run` stays 0.
- Arithmetic:
  - idx is wide enough to hold MAX_WORDS.
  - The address add is ADDR_W bits. BASE_ADDR + 4·MAX_WORDS must not overflow, and elaboration fails otherwise.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state to HDR
  - `in_ready`=0 while asserted, then 1 on the first clock edge after release
  - `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0
  - `busy`=0 while asserted
  - `done`=`error`=`core_run`=0
  - counters and checksum cleared
- `mem_wr_*` are registered. The write strobe is high exactly one cycle, the cycle after the 4th byte of a word is accepted.
- Peak throughput is 4 bytes per 5 cycles. `in_valid` gaps only stretch byte collection.
- CHECK adds one cycle after the header.
- `done`/`core_run` rise the cycle after the final checksum byte is accepted.
- `restart` in DONE: `core_run`, `done` and `error` are 0 and `in_ready` is 1 on the next cycle.
- If reset asserts mid-load, the load is abandoned immediately, with no partial write strobe. The next stream is parsed from the header.

## Structure
- `loader_pkg` holds:
  - `loader_state_t` enum (HDR, CHECK, DATA, WRITE, CSUM, DONE, ERROR)
  - constant `LOADER_FIELD_BYTES` = 4
- Sub-module `word_assembler`:
  - 2-bit byte counter plus 24-bit shift register
  - `clear` input, byte-accept input, `word_done` pulse, 32-bit assembled word output
  - instantiated once and shared by HDR, DATA and CSUM
- The top level wires `core_run` into the `program_counter` stall/reset gating and muxes the memory write port between this loader and the LSU on `core_run`.

## Test plan
- Basic load:
  - Stimulus: N=2, words 0x11223344 and 0xAABBCCDD, checksum 0xBB99FF99, BASE_ADDR=0.
  - Response: writes (0x0, 0x11223344) then (0x4, 0xAABBCCDD); `done`=`core_run`=1; `in_ready`=0.
- Bad checksum:
  - Stimulus: same stream with checksum 0x00000000.
  - Response: both writes still occur; `error`=1; `core_run`=0.
- Invalid count:
  - Stimulus: N=0, then separately N=MAX_WORDS+1.
  - Response: ERROR one cycle after the 4th header byte; no `mem_wr_en` pulse.
- Handshake stress:
  - Stimulus: the basic-load stream with random `in_valid` gaps, and `in_valid` held high through WRITE cycles.
  - Response: identical writes and result; no byte consumed while `in_ready`=0.
- Reset mid-load:
  - Stimulus: assert `rst` during the 2nd payload word.
  - Response: all outputs reset asynchronously; a fresh N=1 stream loads correctly from address BASE_ADDR.
- Restart from DONE:
  - Stimulus: pulse `restart` after a successful load.
  - Response: `core_run`=0 the next cycle; a reload of N=1 with word 0xDEADBEEF and checksum 0xDEADBEEF writes to 0x0 and reaches DONE.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loader_state_t     : the loader's FSM states
//   LOADER_FIELD_BYTES : bytes per stream field (count, payload word, checksum)
package loader_pkg;

  localparam int LOADER_FIELD_BYTES = 4;

  typedef enum logic [2:0] {
    HDR,
    CHECK,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : drop any partially collected word
//   accept     : a byte on data is consumed this cycle
//   data       : incoming byte
//   word_done  : high in the cycle the last byte of a word is accepted
//   word       : assembled word; valid while word_done is high
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // The final byte is not stored: it is combined straight from the input so
  // the caller sees the complete word in the same cycle it is accepted.
  assign word_done = accept && (cnt == 2'(LOADER_FIELD_BYTES - 1));
  assign word      = {data, shift};

  // Bytes enter at the top of the shift register, so after three accepts the
  // first byte sits in the least-significant position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      shift <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (accept) begin
      cnt   <= cnt + 2'd1;
      shift <= {data, shift[23:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Parses a byte stream of
//   word count N, N payload words, XOR checksum (all little-endian, 4 bytes)
// and writes the payload into main memory, then releases the core.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   in_valid/in_data/in_ready: byte stream handshake
//   restart                  : re-arm from DONE or ERROR
//   mem_wr_en/addr/data      : registered memory write port, one-cycle strobe
//   busy                     : load in progress
//   done                     : load verified
//   error                    : load rejected, sticky until restart or reset
//   core_run                 : core may fetch and execute
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              core_run
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  // The highest write address must stay inside the address space.
  if ((64'(BASE_ADDR) + 64'(MAX_WORDS) * 64'd4) > (64'd1 << ADDR_W)) begin : g_addr_range
    $fatal(1, "program_loader: BASE_ADDR + 4*MAX_WORDS overflows ADDR_W");
  end

  loader_state_t    state, next_state;
  logic             armed;
  logic [31:0]      count;
  logic [IDX_W-1:0] idx;
  logic [31:0]      csum;
  logic             accept;
  logic             asm_clear;
  logic             word_done;
  logic [31:0]      word;
  logic             rearm;

  // armed holds the handshake off while reset is applied and for the state
  // register's first cycle, so in_ready/busy come up one edge after release.
  assign in_ready  = armed && (state inside {HDR, DATA, CSUM});
  assign busy      = armed && (state inside {HDR, CHECK, DATA, WRITE, CSUM});
  assign done      = (state == DONE);
  assign core_run  = (state == DONE);
  assign error     = (state == ERROR);
  assign accept    = in_valid && in_ready;
  assign rearm     = restart && (state inside {DONE, ERROR});
  assign asm_clear = rearm;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .accept    (accept),
    .data      (in_data),
    .word_done (word_done),
    .word      (word)
  );

  // State register plus the handshake enable flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HDR;
      armed <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
    end
  end

  // Next-state decode. Restart only matters once a load has finished, either
  // way; during a load it is deliberately ignored.
  always_comb begin
    next_state = state;
    case (state)
      HDR:   if (word_done) next_state = CHECK;
      CHECK: begin
        if (count == 32'd0 || count > MAX_WORDS) next_state = ERROR;
        else                                     next_state = DATA;
      end
      DATA:  if (word_done) next_state = WRITE;
      WRITE: begin
        if ((32'(idx) + 32'd1) < count) next_state = DATA;
        else                            next_state = CSUM;
      end
      CSUM: begin
        if (word_done) next_state = (word == csum) ? DONE : ERROR;
      end
      DONE:    if (restart) next_state = HDR;
      ERROR:   if (restart) next_state = HDR;
      default: next_state = HDR;
    endcase
  end

  // Datapath: header latch, word index, running checksum and the registered
  // write port. The strobe is raised for exactly the WRITE cycle, and the
  // checksum folds in the word being written during that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      idx         <= '0;
      csum        <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= (state == DATA) && word_done;
      if (rearm) begin
        idx  <= '0;
        csum <= '0;
      end
      if (state == HDR && word_done) begin
        count <= word;
      end
      if (state == DATA && word_done) begin
        mem_wr_addr <= BASE_ADDR + (ADDR_W'(idx) << 2);
        mem_wr_data <= word;
      end
      if (state == WRITE) begin
        idx  <= idx + IDX_W'(1);
        csum <= csum ^ mem_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: basic load, restart, bad checksum,
// invalid counts, handshake gaps, reset mid-load and the MAX_WORDS boundary.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        core_run;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq[$];

  program_loader #(
    .ADDR_W    (32),
    .BASE_ADDR (32'h0),
    .MAX_WORDS (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .restart     (restart),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .core_run    (core_run)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr_en) wq.push_back({mem_wr_addr, mem_wr_data});
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte after an optional idle gap and wait until it is taken.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checkOutput("handshake_timeout", 64'(guard), 64'd0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic end_stream();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic check_write(input string tag, input int i, input logic [63:0] exp);
    logic [63:0] obs;
    obs = (i < wq.size()) ? wq[i] : 64'hx;
    checkOutput(tag, obs, exp);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;

    // Reset state while reset is held.
    #12;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_core_run", core_run, 0);
    checkOutput("rst_wr_en", mem_wr_en, 0);
    checkOutput("rst_wr_addr", mem_wr_addr, 0);
    checkOutput("rst_wr_data", mem_wr_data, 0);
    #10;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_busy", busy, 1);

    // Basic load, back-to-back bytes with in_valid high through WRITE.
    wq.delete();
    send_word(32'd2, 0);
    checkOutput("basic_check_in_ready", in_ready, 0);
    checkOutput("basic_check_error", error, 0);
    send_word(32'h11223344, 0);
    checkOutput("basic_w0_strobe", mem_wr_en, 1);
    checkOutput("basic_w0_addr", mem_wr_addr, 32'h0);
    checkOutput("basic_w0_data", mem_wr_data, 32'h11223344);
    checkOutput("basic_w0_in_ready", in_ready, 0);
    send_word(32'hAABBCCDD, 0);
    send_word(32'hBB99FF99, 0);
    end_stream();
    checkOutput("basic_done", done, 1);
    checkOutput("basic_core_run", core_run, 1);
    checkOutput("basic_in_ready", in_ready, 0);
    checkOutput("basic_busy", busy, 0);
    checkOutput("basic_error", error, 0);
    checkOutput("basic_wr_count", 64'(wq.size()), 2);
    check_write("basic_wr0", 0, {32'h0, 32'h11223344});
    check_write("basic_wr1", 1, {32'h4, 32'hAABBCCDD});

    // Restart from DONE and reload a single word.
    pulse_restart();
    checkOutput("restart_core_run", core_run, 0);
    checkOutput("restart_done", done, 0);
    checkOutput("restart_error", error, 0);
    checkOutput("restart_in_ready", in_ready, 1);
    wq.delete();
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 0);
    send_word(32'hDEADBEEF, 0);
    end_stream();
    checkOutput("reload_done", done, 1);
    checkOutput("reload_wr_count", 64'(wq.size()), 1);
    check_write("reload_wr0", 0, {32'h0, 32'hDEADBEEF});

    // Bad checksum; restart held during a payload word must be ignored.
    pulse_restart();
    wq.delete();
    send_word(32'd2, 0);
    send_word(32'h11223344, 0);
    restart = 1'b1;
    send_word(32'hAABBCCDD, 0);
    restart = 1'b0;
    send_word(32'h00000000, 0);
    end_stream();
    checkOutput("badcs_error", error, 1);
    checkOutput("badcs_core_run", core_run, 0);
    checkOutput("badcs_done", done, 0);
    checkOutput("badcs_wr_count", 64'(wq.size()), 2);
    check_write("badcs_wr0", 0, {32'h0, 32'h11223344});
    check_write("badcs_wr1", 1, {32'h4, 32'hAABBCCDD});
    repeat (3) @(posedge clk);
    #1;
    checkOutput("badcs_error_sticky", error, 1);

    // Zero word count: one CHECK cycle, then ERROR, no writes.
    pulse_restart();
    checkOutput("err_restart_error", error, 0);
    wq.delete();
    send_word(32'd0, 0);
    end_stream();
    checkOutput("n0_check_error", error, 0);
    checkOutput("n0_check_in_ready", in_ready, 0);
    @(posedge clk); #1;
    checkOutput("n0_error", error, 1);
    checkOutput("n0_core_run", core_run, 0);

    // Word count one above MAX_WORDS.
    pulse_restart();
    send_word(32'd1025, 0);
    end_stream();
    checkOutput("nmax1_check_error", error, 0);
    @(posedge clk); #1;
    checkOutput("nmax1_error", error, 1);
    checkOutput("invalid_no_writes", 64'(wq.size()), 0);

    // Handshake stress: random in_valid gaps.
    pulse_restart();
    wq.delete();
    send_word(32'd2, 1);
    send_word(32'h11223344, 1);
    send_word(32'hAABBCCDD, 1);
    send_word(32'hBB99FF99, 1);
    end_stream();
    checkOutput("gaps_done", done, 1);
    checkOutput("gaps_core_run", core_run, 1);
    checkOutput("gaps_wr_count", 64'(wq.size()), 2);
    check_write("gaps_wr0", 0, {32'h0, 32'h11223344});
    check_write("gaps_wr1", 1, {32'h4, 32'hAABBCCDD});

    // Reset asserted during the write of the 2nd payload word.
    pulse_restart();
    send_word(32'd2, 0);
    send_word(32'h11223344, 0);
    send_word(32'hAABBCCDD, 0);
    end_stream();
    checkOutput("midrst_pre_strobe", mem_wr_en, 1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_wr_en", mem_wr_en, 0);
    checkOutput("midrst_wr_addr", mem_wr_addr, 0);
    checkOutput("midrst_wr_data", mem_wr_data, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    wq.delete();
    @(posedge clk); #1;
    checkOutput("midrst_rearm_ready", in_ready, 1);
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    send_word(32'hCAFEF00D, 0);
    end_stream();
    checkOutput("midrst_reload_done", done, 1);
    checkOutput("midrst_wr_count", 64'(wq.size()), 1);
    check_write("midrst_wr0", 0, {32'h0, 32'hCAFEF00D});

    // MAX_WORDS itself is accepted: CHECK leads to DATA.
    pulse_restart();
    send_word(32'd1024, 0);
    end_stream();
    @(posedge clk); #1;
    checkOutput("nmax_error", error, 0);
    checkOutput("nmax_in_ready", in_ready, 1);
    checkOutput("nmax_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
